// File: rtl/mem_dbus_ctrl_pkg.sv
// Shared types for the memory-stage data-bus controller: access size, FSM states,
// and packed request/response bundles.
package mem_dbus_ctrl_pkg;

  typedef enum logic [1:0] {MS_BYTE = 2'd0, MS_HALF = 2'd1, MS_WORD = 2'd2, MS_DWORD = 2'd3} msize_t;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  typedef struct packed {
    logic [1:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addrOk;
    logic        dataOk;
    logic [63:0] data;
  } dbus_resp_t;

  // Unshifted byte-enable pattern for an access of the given size.
  function automatic logic [7:0] sizeMask(msize_t s);
    unique case (s)
      MS_BYTE:  return 8'h01;
      MS_HALF:  return 8'h03;
      MS_WORD:  return 8'h0F;
      default:  return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_dbus_ctrl_if.sv
// Data-bus request/response signals between the memory-stage controller and the bus.
interface mem_dbus_ctrl_if #(parameter int ADDR_W = 64);
  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic [1:0]        dreq_size;
  logic [7:0]        dreq_strobe;
  logic [63:0]       dreq_data;
  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [63:0]       dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );
  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/mem_dbus_ctrl_align.sv
// Byte-lane alignment: store strobe/data shifting, load shift/extend, misalign detect.
module mem_align
  import mem_dbus_ctrl_pkg::*;
(
  input  logic        memOp,
  input  logic [2:0]  stOff,
  input  msize_t      stSize,
  input  logic [63:0] wdata,
  output logic [7:0]  strobe,
  output logic [63:0] sdata,
  output logic        misalign,
  input  logic [2:0]  ldOff,
  input  msize_t      ldSize,
  input  logic        ldSext,
  input  logic [63:0] raw,
  output logic [63:0] ldata
);
  logic [63:0] shifted;

  always_comb begin
    misalign = 1'b0;
    unique case (stSize)
      MS_BYTE:  misalign = 1'b0;
      MS_HALF:  misalign = stOff[0];
      MS_WORD:  misalign = |stOff[1:0];
      MS_DWORD: misalign = |stOff;
    endcase
    misalign = misalign & memOp;
    strobe   = sizeMask(stSize) << stOff;
    sdata    = wdata << {stOff, 3'b000};
  end

  // Load side works on the latched lane/size so the raw beat can arrive any cycle later.
  always_comb begin
    shifted = raw >> {ldOff, 3'b000};
    ldata   = shifted;
    unique case (ldSize)
      MS_BYTE:  ldata = {{56{ldSext & shifted[7]}},  shifted[7:0]};
      MS_HALF:  ldata = {{48{ldSext & shifted[15]}}, shifted[15:0]};
      MS_WORD:  ldata = {{32{ldSext & shifted[31]}}, shifted[31:0]};
      MS_DWORD: ldata = shifted;
    endcase
  end
endmodule

// File: rtl/mem_dbus_ctrl.sv
// Memory-stage data-bus controller: issues one aligned load/store per instruction,
// stalls the pipe until the bus returns data, and presents the aligned load result.
module mem_dbus_ctrl
  import mem_dbus_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  input  logic [1:0]        msize,
  input  logic              sext,
  input  logic              advance,
  input  logic              flush,
  mem_dbus_ctrl_if.master   dbus,
  output logic              stall,
  output logic              done,
  output logic              misalign,
  output logic [63:0]       rdata
);
  state_t            state, stateNxt;
  logic              killQ, killNxt;
  dbus_req_t         reqQ;
  logic [ADDR_W-1:0] addrQ;
  logic              sextQ, loadQ;
  logic [63:0]       rdataQ;
  dbus_resp_t        resp;

  logic              memOp, misRaw, accept, capture;
  logic [7:0]        stb;
  logic [63:0]       sdata, ldata;

  assign memOp = req_valid & (is_load | is_store);
  assign resp  = '{addrOk: dbus.dresp_addr_ok, dataOk: dbus.dresp_data_ok, data: dbus.dresp_data};

  mem_align uAlign (
    .memOp    (memOp),
    .stOff    (addr[2:0]),
    .stSize   (msize_t'(msize)),
    .wdata    (wdata),
    .strobe   (stb),
    .sdata    (sdata),
    .misalign (misRaw),
    .ldOff    (addrQ[2:0]),
    .ldSize   (msize_t'(reqQ.size)),
    .ldSext   (sextQ),
    .raw      (resp.data),
    .ldata    (ldata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      killQ  <= 1'b0;
      reqQ   <= '0;
      addrQ  <= '0;
      sextQ  <= 1'b0;
      loadQ  <= 1'b0;
      rdataQ <= '0;
    end else begin
      state <= stateNxt;
      killQ <= killNxt;
      if (accept) begin
        addrQ       <= addr;
        reqQ.size   <= msize;
        reqQ.strobe <= is_store ? stb : 8'h00;
        reqQ.data   <= is_store ? sdata : 64'h0;
        sextQ       <= sext;
        loadQ       <= is_load;
      end
      if (capture) rdataQ <= loadQ ? ldata : 64'h0;
    end
  end

  // A killed access still runs its bus handshake to completion, then skips DONE.
  always_comb begin
    stateNxt = state;
    killNxt  = killQ;
    accept   = 1'b0;
    capture  = 1'b0;
    stall    = 1'b0;
    done     = 1'b0;
    misalign = 1'b0;
    unique case (state)
      IDLE: begin
        killNxt  = 1'b0;
        misalign = misRaw;
        if (memOp && !misRaw && !flush) begin
          accept   = 1'b1;
          stall    = 1'b1;
          stateNxt = REQ;
        end
      end
      REQ: begin
        killNxt = killQ | flush;
        stall   = !(killQ | flush);
        if (resp.addrOk && resp.dataOk) begin
          capture  = !(killQ | flush);
          stateNxt = (killQ | flush) ? IDLE : DONE;
          killNxt  = 1'b0;
        end else if (resp.addrOk) begin
          stateNxt = WAIT;
        end
      end
      WAIT: begin
        killNxt = killQ | flush;
        stall   = !(killQ | flush);
        if (resp.dataOk) begin
          capture  = !(killQ | flush);
          stateNxt = (killQ | flush) ? IDLE : DONE;
          killNxt  = 1'b0;
        end
      end
      DONE: begin
        if (flush) stateNxt = IDLE;
        else begin
          done = 1'b1;
          if (advance) stateNxt = IDLE;
        end
      end
    endcase
  end

  assign dbus.dreq_valid  = (state == REQ);
  assign dbus.dreq_addr   = addrQ;
  assign dbus.dreq_size   = reqQ.size;
  assign dbus.dreq_strobe = reqQ.strobe;
  assign dbus.dreq_data   = reqQ.data;
  assign rdata            = rdataQ;
endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed plus randomized check of mem_dbus_ctrl against a byte-level reference model.
module tb_mem_dbus_ctrl;
  localparam int ADDR_W = 64;

  logic              clk, resetn;
  logic              req_valid, is_load, is_store, sext, advance, flush;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       wdata, rdata;
  logic [1:0]        msize;
  logic              stall, done, misalign;
  int                vecs, errs;

  mem_dbus_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_dbus_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .is_load(is_load), .is_store(is_store),
    .addr(addr), .wdata(wdata), .msize(msize), .sext(sext), .advance(advance), .flush(flush),
    .dbus(bus), .stall(stall), .done(done), .misalign(misalign), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model works byte by byte from the access rules.
  function automatic logic [63:0] refLoad(logic [63:0] raw, logic [63:0] a, logic [1:0] sz, bit sx);
    int nb = 1 << sz;
    int off = int'(a % 8);
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = raw[8*(off+i) +: 8];
    if (sx && v[8*nb-1]) for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] refStrobe(logic [63:0] a, logic [1:0] sz);
    int nb = 1 << sz;
    int off = int'(a % 8);
    logic [7:0] s = '0;
    for (int i = 0; i < 8; i++) s[i] = (i >= off) && (i < off + nb);
    return s;
  endfunction

  function automatic logic [63:0] refStData(logic [63:0] a, logic [63:0] wd);
    int off = int'(a % 8);
    logic [63:0] d = '0;
    for (int i = 0; i < 8; i++) if (i >= off) d[8*i +: 8] = wd[8*(i-off) +: 8];
    return d;
  endfunction

  // One memory-stage instruction. aD/dD: REQ-relative cycle of addr_ok/data_ok (dD >= aD).
  // flushK: cycle (relative to first REQ cycle) at which flush pulses, -1 for none.
  task automatic runTxn(input bit ld, input logic [1:0] sz, input logic [63:0] a, input logic [63:0] wd,
                        input bit sx, input logic [63:0] raw, input int aD, input int dD,
                        input int advD, input int flushK, input bit flushDone);
    bit mis = (a % (64'd1 << sz)) != 0;
    bit killed = 0;
    req_valid = 1; is_load = ld; is_store = !ld; addr = a; wdata = wd; msize = sz; sext = sx;
    flush = 0; advance = 0;
    @(negedge clk);
    if (mis) begin
      chk("misalign", {63'd0, misalign}, 1);
      chk("misStall", {63'd0, stall}, 0);
      @(posedge clk); #1;
      req_valid = 0;
      @(negedge clk);
      chk("misNoReq", {61'd0, bus.dreq_valid, stall, done}, 0);
      @(posedge clk); #1;
      return;
    end
    chk("accMisalign", {63'd0, misalign}, 0);
    chk("accStall", {63'd0, stall}, 1);
    @(posedge clk); #1;
    req_valid = 0; is_load = 0; is_store = 0; wdata = {$urandom, $urandom};
    for (int k = 0; k <= dD; k++) begin
      bus.dresp_addr_ok = (k == aD);
      bus.dresp_data_ok = (k == dD);
      bus.dresp_data    = (k == dD) ? raw : {$urandom, $urandom};
      flush = (k == flushK);
      if (k == flushK) killed = 1;
      @(negedge clk);
      if (k <= aD) begin
        chk("dreqValid", {63'd0, bus.dreq_valid}, 1);
        chk("dreqAddr", bus.dreq_addr, a);
        chk("dreqSize", {62'd0, bus.dreq_size}, {62'd0, sz});
        chk("dreqStrobe", {56'd0, bus.dreq_strobe}, ld ? 64'd0 : {56'd0, refStrobe(a, sz)});
        if (!ld) chk("dreqData", bus.dreq_data, refStData(a, wd));
      end else begin
        chk("waitNoValid", {63'd0, bus.dreq_valid}, 0);
      end
      chk("busyStall", {63'd0, stall}, {63'd0, !killed});
      chk("busyDone", {63'd0, done}, 0);
      @(posedge clk); #1;
    end
    bus.dresp_addr_ok = 0; bus.dresp_data_ok = 0; bus.dresp_data = {$urandom, $urandom}; flush = 0;
    if (killed) begin
      @(negedge clk);
      chk("killIdle", {61'd0, done, stall, bus.dreq_valid}, 0);
      @(posedge clk); #1;
      return;
    end
    if (flushDone) begin
      flush = 1;
      @(negedge clk);
      chk("flushDoneLow", {62'd0, done, stall}, 0);
      @(posedge clk); #1;
      flush = 0;
      @(negedge clk);
      chk("postFlushIdle", {63'd0, done}, 0);
      @(posedge clk); #1;
      return;
    end
    for (int j = 0; j <= advD; j++) begin
      advance = (j == advD);
      @(negedge clk);
      chk("done", {63'd0, done}, 1);
      chk("doneStall", {63'd0, stall}, 0);
      chk("rdata", rdata, ld ? refLoad(raw, a, sz, sx) : 64'd0);
      @(posedge clk); #1;
    end
    advance = 0;
    @(negedge clk);
    chk("idleAfter", {62'd0, done, bus.dreq_valid}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs = 0; errs = 0;
    resetn = 0; req_valid = 0; is_load = 0; is_store = 0; sext = 0; advance = 0; flush = 0;
    addr = '0; wdata = '0; msize = '0;
    bus.dresp_addr_ok = 0; bus.dresp_data_ok = 0; bus.dresp_data = '0;
    #12;
    chk("rstState", {60'd0, bus.dreq_valid, stall, done, misalign}, 0);
    chk("rstRdata", rdata, 0);
    @(posedge clk); #1;
    resetn = 1;

    // zero-wait sign-extended word load: done two cycles after acceptance
    runTxn(1, 2'd2, 64'h1004, 64'h0, 1, 64'h80000000_00000000, 0, 0, 0, -1, 0);
    // byte store with three cycles of address back-pressure
    runTxn(0, 2'd0, 64'h2003, 64'hAB, 0, 64'h0, 3, 3, 0, -1, 0);
    // misaligned half load
    runTxn(1, 2'd1, 64'h3001, 64'h0, 0, 64'h0, 0, 0, 0, -1, 0);
    // addr_ok cycle 1, data_ok cycle 4, advance held low two cycles
    runTxn(1, 2'd3, 64'h5008, 64'h0, 0, 64'h0123_4567_89AB_CDEF, 0, 3, 2, -1, 0);
    // flush during WAIT, then a normal load
    runTxn(1, 2'd2, 64'h6000, 64'h0, 0, 64'hDEAD_BEEF_CAFE_F00D, 0, 3, 0, 2, 0);
    runTxn(1, 2'd1, 64'h6006, 64'h0, 1, 64'h8001_0000_0000_0000, 1, 1, 0, -1, 0);
    // flush during REQ, and flush while done
    runTxn(0, 2'd3, 64'h7000, 64'h1122_3344_5566_7788, 0, 64'h0, 2, 2, 0, 0, 0);
    runTxn(1, 2'd0, 64'h7005, 64'h0, 0, 64'h0000_FF00_0000_0000, 0, 0, 0, -1, 1);

    for (int n = 0; n < 60; n++) begin
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic [63:0] a  = {$urandom, $urandom};
      int aD = $urandom_range(0, 3);
      int dD = aD + $urandom_range(0, 3);
      int fk = ($urandom_range(0, 5) == 0) ? $urandom_range(0, dD) : -1;
      if ($urandom_range(0, 4) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      runTxn(1'($urandom_range(0, 1)), sz, a, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, aD, dD, $urandom_range(0, 2), fk, $urandom_range(0, 7) == 0);
    end

    // make sure rdata is non-zero going into the reset test
    runTxn(1, 2'd3, 64'h8000, 64'h0, 0, 64'h5A5A_5A5A_5A5A_5A5A, 0, 0, 0, -1, 0);
    req_valid = 1; is_load = 1; is_store = 0; addr = 64'h9000; msize = 2'd3; sext = 0;
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    chk("rstPreValid", {63'd0, bus.dreq_valid}, 1);
    resetn = 0;
    #1;
    chk("rstMidValid", {63'd0, bus.dreq_valid}, 0);
    chk("rstMidOuts", {61'd0, stall, done, misalign}, 0);
    chk("rstMidRdata", rdata, 0);
    @(posedge clk); #1;
    resetn = 1;
    bus.dresp_addr_ok = 1; bus.dresp_data_ok = 1; bus.dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("rstIgnoreResp", {62'd0, done, bus.dreq_valid}, 0);
    @(posedge clk); #1;
    bus.dresp_addr_ok = 0; bus.dresp_data_ok = 0;
    @(negedge clk);
    chk("rstStillIdle", {61'd0, done, stall, bus.dreq_valid}, 0);
    chk("rstRdataKept", rdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mem_dbus_ctrl.md
MEM_DBUS_CTRL -- requirements
Module: mem_dbus_ctrl

Interface
REQ-001 Parameter ADDR_W, default 64: data-bus address width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  memory stage holds a valid instruction.
REQ-005 is_load / is_store  input  1 each  instruction is load / store (never both).
REQ-006 addr  input  ADDR_W  effective address.
REQ-007 wdata  input  64  store data, right-aligned.
REQ-008 msize  input  2  access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-009 sext  input  1  sign-extend load result.
REQ-010 advance  input  1  downstream accepts the memory-stage result this cycle.
REQ-011 flush  input  1  kill the current memory-stage instruction.
REQ-012 dreq_valid  output  1  data-bus request valid.
REQ-013 dreq_addr / dreq_size / dreq_strobe / dreq_data  output  ADDR_W / 2 / 8 / 64  request fields; strobe all-zero means read.
REQ-014 dresp_addr_ok / dresp_data_ok  input  1 each  bus accepted address / returned data.
REQ-015 dresp_data  input  64  raw bus read data.
REQ-016 stall  output  1  hold memory stage and everything upstream.
REQ-017 done  output  1  access complete; rdata valid.
REQ-018 rdata  output  64  aligned, extended load result.
REQ-019 misalign  output  1  address not aligned to msize; no bus access issued.

Function
REQ-020 FSM states IDLE, REQ, WAIT, DONE.
REQ-021 IDLE: req_valid & (is_load|is_store) & !misalign & !flush -> latch addr, size, strobe, shifted data, sext, lane; go REQ; stall=1.
REQ-022 IDLE with no memory op, or flush: stall=0, done=0, no state change.
REQ-023 misalign = req_valid & memory op & (half: addr[0]; word: addr[1:0]!=0; dword: addr[2:0]!=0), combinational in IDLE; stall=0 that cycle, no request.
REQ-024 REQ: dreq_valid=1 from registered fields; addr_ok & data_ok -> DONE capturing data; addr_ok only -> WAIT; neither -> stay.
REQ-025 dreq_valid and all dreq fields stay constant from first assertion until addr_ok.
REQ-026 WAIT: dreq_valid=0; data_ok -> DONE capturing dresp_data.
REQ-027 DONE: done=1, stall=0; advance -> IDLE; otherwise hold rdata and done.
REQ-028 Store strobe: byte 8'h01, half 8'h03, word 8'h0F, dword 8'hFF, each shifted left by addr[2:0]; dreq_data = wdata shifted left by 8*addr[2:0].
REQ-029 Load: rdata = dresp_data shifted right by 8*addr[2:0], truncated to size, sign- or zero-extended to 64 per sext.
REQ-030 Stores complete on data_ok like loads; rdata = 0 for stores.
REQ-031 flush in REQ or WAIT sets kill flag: bus transaction still completes, then IDLE directly, done never asserted, stall=0 from the flush cycle on.
REQ-032 flush in DONE -> IDLE next cycle; done=0 from the flush cycle.
REQ-033 Latency: zero-wait bus (addr_ok & data_ok in first REQ cycle) gives done two cycles after acceptance.

Reset
REQ-034 resetn low -> immediately state IDLE, dreq_valid=0, stall=0, done=0, misalign=0, rdata=0, kill=0, latched fields=0.
REQ-035 Reset mid-transaction abandons it; no response after reset release is consumed.

Structure
REQ-036 Shared package holds msize_t, FSM state enum, dbus_req_t, dbus_resp_t.
REQ-037 One combinational sub-module mem_align: strobe/data shift for stores, shift/extend for loads, misalign detection.

Verification
REQ-038 Zero-wait word load, addr 0x1004, data 0x80000000_00000000, sext=1 -> dreq_strobe 0, done at cycle+2, rdata 0xFFFFFFFF_80000000.
REQ-039 Byte store addr 0x2003, wdata 0xAB -> strobe 8'h08, dreq_data[31:24]=0xAB, fields stable across 3 cycles of addr_ok=0.
REQ-040 Half load addr 0x3001 -> misalign=1, dreq_valid never 1, stall=0.
REQ-041 addr_ok cycle 1, data_ok cycle 4, advance low 2 cycles -> WAIT held, done held 2 cycles, IDLE after advance.
REQ-042 flush during WAIT -> no done, stall=0, IDLE after data_ok; next load accepted normally.
REQ-043 resetn low while in REQ -> dreq_valid 0 same cycle, state IDLE, all outputs 0.
